// File: rtl/core_cmd_sequencer.sv
// Command FIFO plus a fetch/issue/wait/clear sequencer that drives the ComputeCore
// command port, gates host BRAM access and records sticky error conditions.

module core_cmd_sequencer #(
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int TIMEOUT = 1048576,
    parameter int SETTLE  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [34:0] cmd_in,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        start,
    input  logic        clear_err,
    output logic [34:0] command_out,
    output logic        command_we0,
    output logic        command_we1,
    input  logic        done_ins_computation,
    input  logic        error_trng,
    output logic        busy,
    output logic        ext_grant,
    output logic        seq_done,
    output logic        err_timeout,
    output logic        err_illegal,
    output logic        err_trng,
    output logic [15:0] issued_count
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int SW = $clog2(SETTLE + 1);
    localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_ISSUE  = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_CLEAR  = 3'd4;
    localparam logic [2:0] S_SETTLE = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    function automatic logic f_ins_legal(input logic [4:0] ins);
        case (ins)
            5'd18, 5'd19, 5'd20, 5'd22, 5'd23, 5'd24: f_ins_legal = 1'b1;
            default:                                  f_ins_legal = 1'b0;
        endcase
    endfunction

    logic [34:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0]   r_count, w_count_nxt;
    logic [2:0]    r_state, w_state_nxt;
    logic [TW-1:0] r_wait_cnt;
    logic [SW-1:0] r_settle_cnt;
    logic [34:0]   r_command_out, w_head;
    logic [15:0]   r_issued_count;
    logic          r_cmd_ready, r_command_we0, r_busy, r_ext_grant, r_seq_done;
    logic          r_err_timeout, r_err_illegal, r_err_trng;
    logic          w_push, w_pop, w_flush, w_start_go, w_start_empty;
    logic          w_set_illegal, w_set_timeout, w_set_trng;

    assign w_push = cmd_valid & r_cmd_ready;
    assign w_head = r_mem[r_rd_ptr];

    // Next-state and per-cycle action decode
    always_comb begin
        w_state_nxt   = r_state;
        w_pop         = 1'b0;
        w_flush       = 1'b0;
        w_start_go    = 1'b0;
        w_start_empty = 1'b0;
        w_set_illegal = 1'b0;
        w_set_timeout = 1'b0;
        w_set_trng    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && (r_count != (AW+1)'(0))) begin
                    w_state_nxt = S_FETCH;
                    w_start_go  = 1'b1;
                end else begin
                    w_start_empty = start;
                end
            end
            S_FETCH: begin
                w_pop = 1'b1;
                if (f_ins_legal(w_head[4:0])) begin
                    w_state_nxt = S_ISSUE;
                end else begin
                    w_set_illegal = 1'b1;
                    w_state_nxt   = (r_count > (AW+1)'(1)) ? S_FETCH : S_DONE;
                end
            end
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT: begin
                w_set_trng = error_trng & (r_command_out[4:0] == 5'd18);
                if (done_ins_computation) begin
                    w_state_nxt = S_CLEAR;
                end else if (r_wait_cnt == TO_LAST) begin
                    w_set_timeout = 1'b1;
                    w_flush       = 1'b1;
                    w_state_nxt   = S_CLEAR;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_CLEAR: w_state_nxt = S_SETTLE;
            S_SETTLE: begin
                if (r_settle_cnt == SETTLE_LAST) begin
                    w_state_nxt = (r_count != (AW+1)'(0)) ? S_FETCH : S_DONE;
                end else begin
                    w_state_nxt = S_SETTLE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FIFO occupancy; a flush keeps only a push landing in the same cycle
    always_comb begin
        if (w_flush) begin
            w_count_nxt = w_push ? (AW+1)'(1) : (AW+1)'(0);
        end else begin
            w_count_nxt = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    // FIFO storage, written on every accepted push
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= cmd_in;
        end
    end

    // FIFO pointers and count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= AW'(0);
            r_rd_ptr <= AW'(0);
            r_count  <= (AW+1)'(0);
        end else begin
            r_wr_ptr <= w_push ? (r_wr_ptr + AW'(1)) : r_wr_ptr;
            if (w_flush) begin
                r_rd_ptr <= r_wr_ptr;
            end else if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
            r_count <= w_count_nxt;
        end
    end

    // Sequencer state, counters, and outputs registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_wait_cnt     <= TW'(0);
            r_settle_cnt   <= SW'(0);
            r_command_out  <= 35'd0;
            r_command_we0  <= 1'b0;
            r_busy         <= 1'b0;
            r_ext_grant    <= 1'b1;
            r_seq_done     <= 1'b0;
            r_cmd_ready    <= 1'b1;
            r_issued_count <= 16'd0;
            r_err_timeout  <= 1'b0;
            r_err_illegal  <= 1'b0;
            r_err_trng     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_wait_cnt   <= (r_state == S_ISSUE) ? TW'(0) :
                            (r_state == S_WAIT)  ? (r_wait_cnt + TW'(1)) : r_wait_cnt;
            r_settle_cnt <= (r_state == S_CLEAR)  ? SW'(0) :
                            (r_state == S_SETTLE) ? (r_settle_cnt + SW'(1)) : r_settle_cnt;
            case (w_state_nxt)
                S_ISSUE: r_command_out <= w_head;
                S_CLEAR: r_command_out <= 35'd0;
                default: r_command_out <= r_command_out;
            endcase
            r_command_we0 <= (w_state_nxt == S_ISSUE) || (w_state_nxt == S_CLEAR);
            r_busy        <= (w_state_nxt != S_IDLE);
            r_ext_grant   <= (w_state_nxt == S_IDLE);
            r_seq_done    <= (w_state_nxt == S_DONE) || w_start_empty;
            // Entering FETCH guarantees a pop next cycle, so space is offered early
            r_cmd_ready   <= (w_count_nxt != (AW+1)'(DEPTH)) || (w_state_nxt == S_FETCH);
            if (w_start_go) begin
                r_issued_count <= 16'd0;
            end else if (w_state_nxt == S_ISSUE) begin
                r_issued_count <= r_issued_count + 16'd1;
            end else begin
                r_issued_count <= r_issued_count;
            end
            r_err_timeout <= w_set_timeout | (r_err_timeout & ~clear_err);
            r_err_illegal <= w_set_illegal | (r_err_illegal & ~clear_err);
            r_err_trng    <= w_set_trng    | (r_err_trng    & ~clear_err);
        end
    end

    assign cmd_ready    = r_cmd_ready;
    assign command_out  = r_command_out;
    assign command_we0  = r_command_we0;
    assign command_we1  = 1'b0;
    assign busy         = r_busy;
    assign ext_grant    = r_ext_grant;
    assign seq_done     = r_seq_done;
    assign err_timeout  = r_err_timeout;
    assign err_illegal  = r_err_illegal;
    assign err_trng     = r_err_trng;
    assign issued_count = r_issued_count;

endmodule

// File: tb/tb_core_cmd_sequencer.sv
// Self-checking bench: directed programs plus random command streams scored against
// a queue model that predicts issue order, event timing and error flags.

module tb_core_cmd_sequencer;

    localparam int TMO = 64;
    localparam int STL = 2;

    logic        clk = 1'b0;
    logic        rst_n, cmd_valid, start, clear_err, done, error_trng;
    logic [34:0] cmd_in;
    logic        cmd_ready, command_we0, command_we1, busy, ext_grant, seq_done;
    logic        err_timeout, err_illegal, err_trng;
    logic [34:0] command_out;
    logic [15:0] issued_count;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [34:0] q[$];
    logic [15:0] last_issued = 16'd0;
    logic [4:0]  legal_tab[6] = '{5'd18, 5'd19, 5'd20, 5'd22, 5'd23, 5'd24};
    logic [4:0]  ill_tab[6]   = '{5'd0, 5'd7, 5'd17, 5'd21, 5'd25, 5'd31};

    core_cmd_sequencer #(.DEPTH(16), .AW(4), .TIMEOUT(TMO), .SETTLE(STL)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_in(cmd_in), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .start(start), .clear_err(clear_err),
        .command_out(command_out), .command_we0(command_we0), .command_we1(command_we1),
        .done_ins_computation(done), .error_trng(error_trng), .busy(busy),
        .ext_grant(ext_grant), .seq_done(seq_done), .err_timeout(err_timeout),
        .err_illegal(err_illegal), .err_trng(err_trng), .issued_count(issued_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_legal(input logic [4:0] ins);
        return ins inside {5'd18, 5'd19, 5'd20, 5'd22, 5'd23, 5'd24};
    endfunction

    function automatic int count_legal();
        int n = 0;
        foreach (q[i]) if (is_legal(q[i][4:0])) n++;
        return n;
    endfunction

    function automatic int lead_illegal();
        int k = 0;
        while (k < q.size() && !is_legal(q[k][4:0])) k++;
        return k;
    endfunction

    function automatic logic [34:0] rand_cmd();
        logic [29:0] ops;
        int          r;
        ops = 30'($urandom);
        r   = $urandom_range(9, 0);
        if (r < 8) return {ops, legal_tab[r % 6]};
        else       return {ops, ill_tab[$urandom_range(5, 0)]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic push(input logic [34:0] c);
        cmd_in    = c;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        q.push_back(c);
    endtask

    task automatic clr();
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        check("clr_timeout", err_timeout, 1'b0);
        check("clr_illegal", err_illegal, 1'b0);
        check("clr_trng", err_trng, 1'b0);
    endtask

    // Pulse start and score one whole program against the queue model.
    task automatic run(input int dlo, input int dhi, input bit tmo, input bit hold, input bit pushmid);
        int          s, k, exp_issue, exp_nop, exp_end, exp_n, done_at, issue_cyc, last_nop;
        bit          pending, finished, exp_ill, exp_trng, exp_tmo, exp_busy;
        logic [34:0] c;
        logic [4:0]  cur_ins;
        s = cyc; pending = 0; finished = 0; exp_ill = 0; exp_trng = 0; exp_tmo = 0;
        exp_busy = (q.size() > 0);
        exp_n = count_legal();
        last_nop = -100; done_at = -1; issue_cyc = -100; exp_nop = -1; cur_ins = 5'd0;
        if (exp_n > 0) begin
            exp_issue = s + 2 + lead_illegal();
            exp_end   = -1;
        end else begin
            exp_issue = -1;
            exp_end   = s + 1 + q.size();
        end
        start = 1'b1;
        while (!finished && cyc < s + 4000) begin
            step();
            start = 1'b0; cmd_valid = 1'b0; done = 1'b0; error_trng = 1'b0;
            check("busy", busy, exp_busy);
            check("ext_grant", ext_grant, !exp_busy);
            if (cyc == s + 1 && q.size() == 16) check("ready_in_fetch", cmd_ready, 1'b1);
            if (command_we0 && !pending) begin
                check("issue_time", cyc, exp_issue);
                k = lead_illegal();
                if (k > 0) exp_ill = 1;
                repeat (k) void'(q.pop_front());
                c = (q.size() > 0) ? q.pop_front() : 35'd0;
                check("issue_cmd", command_out, c);
                cur_ins = c[4:0]; pending = 1; issue_cyc = cyc; exp_issue = -1;
                if (tmo) begin
                    done_at = -1;
                    exp_nop = cyc + TMO + 1;
                end else begin
                    done_at = cyc + $urandom_range(dhi, dlo);
                    exp_nop = done_at + 1;
                end
                if (pushmid && q.size() < 12 && $urandom_range(1, 0) == 1) begin
                    c = rand_cmd();
                    cmd_in = c; cmd_valid = 1'b1;
                    q.push_back(c);
                    if (is_legal(c[4:0])) exp_n++;
                end
            end else if (command_we0) begin
                check("nop_time", cyc, exp_nop);
                check("nop_cmd", command_out, 35'd0);
                if (tmo) begin
                    check("err_timeout_set", err_timeout, 1'b1);
                    exp_tmo = 1;
                    exp_n -= count_legal();
                    q.delete();
                end
                pending = 0; last_nop = cyc;
                if (count_legal() > 0) exp_issue = cyc + STL + 2 + lead_illegal();
                else                   exp_end   = cyc + STL + 1 + q.size();
            end
            if (tmo && pending && cyc == issue_cyc + TMO) check("timeout_not_early", err_timeout, 1'b0);
            if (seq_done) begin
                check("seq_done_time", cyc, exp_end);
                finished = 1;
            end
            if (pending && !tmo && cyc == done_at) begin
                done = 1'b1;
                error_trng = 1'($urandom_range(1, 0));
                if (error_trng && cur_ins == 5'd18) exp_trng = 1;
            end
            if (hold && pending && done_at >= 0 && cyc > done_at) done = 1'b1;
            if (hold && !pending && cyc <= last_nop + STL) done = 1'b1;
            if (hold && pending && cyc == issue_cyc + 1) start = 1'b1;
        end
        done = 1'b0; start = 1'b0; cmd_valid = 1'b0; error_trng = 1'b0;
        check("seq_done_seen", finished, 1'b1);
        if (lead_illegal() > 0) exp_ill = 1;
        q.delete();
        if (exp_busy) last_issued = 16'(exp_n);
        check("issued_count", issued_count, last_issued);
        check("end_err_illegal", err_illegal, exp_ill);
        check("end_err_trng", err_trng, exp_trng);
        check("end_err_timeout", err_timeout, exp_tmo);
        step();
        check("idle_busy", busy, 1'b0);
        check("idle_grant", ext_grant, 1'b1);
        check("idle_seq_done", seq_done, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; start = 1'b0; clear_err = 1'b0;
        done = 1'b0; error_trng = 1'b0; cmd_in = 35'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_command_out", command_out, 35'd0);
        check("rst_we0", command_we0, 1'b0);
        check("rst_we1", command_we1, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_grant", ext_grant, 1'b1);
        check("rst_seq_done", seq_done, 1'b0);
        check("rst_err_timeout", err_timeout, 1'b0);
        check("rst_err_illegal", err_illegal, 1'b0);
        check("rst_err_trng", err_trng, 1'b0);
        check("rst_issued", issued_count, 16'd0);
        check("rst_ready", cmd_ready, 1'b1);
        #2 rst_n = 1'b1;
        step();

        // Single command, done 10 cycles after the issue
        push({10'h100, 10'd0, 10'd0, 5'd22});
        run(10, 10, 1'b0, 1'b0, 1'b0);
        clr();

        // Fill the FIFO completely, then drain it
        for (int i = 0; i < 16; i++) begin
            push({30'($urandom), 5'd24});
            if (i == 14) check("ready_15", cmd_ready, 1'b1);
        end
        check("ready_full", cmd_ready, 1'b0);
        run(5, 5, 1'b0, 1'b0, 1'b0);
        clr();

        // Illegal opcode is dropped and flagged
        push({30'($urandom), 5'd7});
        push({30'($urandom), 5'd18});
        run(3, 8, 1'b0, 1'b0, 1'b0);
        clr();

        // Timeout aborts and flushes the rest of the program
        push({30'($urandom), 5'd19});
        push({30'($urandom), 5'd19});
        run(1, 1, 1'b1, 1'b0, 1'b0);
        clr();

        // Start during WAIT and done held high through SETTLE
        for (int i = 0; i < 3; i++) push(rand_cmd());
        run(2, 6, 1'b0, 1'b1, 1'b0);
        clr();

        // Asynchronous reset in the middle of WAIT
        push({30'($urandom), 5'd20});
        push({30'($urandom), 5'd23});
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 20 && !command_we0; i++) step();
        check("rst_mid_issue_seen", command_we0, 1'b1);
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        check("arst_we0", command_we0, 1'b0);
        check("arst_command_out", command_out, 35'd0);
        check("arst_busy", busy, 1'b0);
        check("arst_grant", ext_grant, 1'b1);
        check("arst_issued", issued_count, 16'd0);
        check("arst_ready", cmd_ready, 1'b1);
        #3 rst_n = 1'b1;
        q.delete();
        last_issued = 16'd0;
        step();
        run(1, 1, 1'b0, 1'b0, 1'b0);

        // Random programs with pushes arriving while the sequencer runs
        for (int p = 0; p < 6; p++) begin
            int n;
            n = $urandom_range(10, 1);
            for (int i = 0; i < n; i++) push(rand_cmd());
            run(1, 15, 1'b0, 1'b0, 1'b1);
            clr();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/core_cmd_sequencer.md
Name: core_cmd_sequencer

Overview:
- Queues 35-bit compute-core commands from the host and issues them one at a time to the ComputeCore command port.
- Each command is written through command_we0; the sequencer waits for done_ins_computation, then writes an all-zero NOP command so the unit units return to reset.
- Gates host BRAM access (ext_grant) while a program runs, and flags timeouts, illegal opcodes and TRNG errors.
- Sits between the host/bus interface and ComputeCore.

Parameters:
- DEPTH, 16, command FIFO entries (power of 2).
- AW, 4, log2(DEPTH).
- TIMEOUT, 1048576, maximum cycles in WAIT before abort (fits 21 bits).
- SETTLE, 2, NOP hold cycles after CLEAR, during which done is ignored (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_in  in  35  command {OP3,OP2,OP1,INS}, INS = bits[4:0].
- cmd_valid  in  1  host push request.
- cmd_ready  out  1  FIFO not full.
- start  in  1  run the queued program; single-cycle pulse.
- clear_err  in  1  clears sticky error flags.
- command_out  out  35  to ComputeCore command_in.
- command_we0  out  1  to ComputeCore command_we0.
- command_we1  out  1  tied 0.
- done_ins_computation  in  1  from ComputeCore.
- error_trng  in  1  from ComputeCore.
- busy  out  1  high in any state other than IDLE.
- ext_grant  out  1  equals ~busy; host may drive address_ext/wea_ext only when this is high.
- seq_done  out  1  one-cycle pulse at program end.
- err_timeout, err_illegal, err_trng  out  1 each  sticky error flags.
- issued_count  out  16  commands issued since the last start; wraps.

Behaviour:
Reset (async, rst_n=0):
- FIFO empties; state goes to IDLE.
- command_out=0, command_we0=0, busy=0, ext_grant=1, seq_done=0.
- All error flags and issued_count are 0.
- Reset mid-program aborts immediately, with no NOP write.

FIFO:
- Push occurs when cmd_valid & cmd_ready, in any state.
- A push on full is impossible (cmd_ready=0).
- Simultaneous push and pop is allowed; the count is unchanged.

States:
- IDLE:
  - start=1 with FIFO non-empty -> FETCH; issued_count cleared.
  - start=1 with FIFO empty -> seq_done pulses the next cycle; stays IDLE.
  - start while busy is ignored.
- FETCH:
  - Pop the head entry.
  - Legal INS is {18,19,20,22,23,24}. Legal -> ISSUE.
  - Illegal -> set err_illegal, drop the entry. Then go to FETCH if the FIFO is non-empty, else to DONE.
- ISSUE (1 cycle):
  - command_out = popped word, command_we0 = 1.
  - issued_count increments.
  - Load the timeout counter with 0 -> WAIT.
- WAIT:
  - command_we0 = 0; command_out holds.
  - done_ins_computation=1 -> CLEAR.
  - If error_trng=1 while INS=18, set err_trng.
  - When the counter reaches TIMEOUT-1 without done: set err_timeout, flush the FIFO, then -> CLEAR.
  - done and timeout in the same cycle: done wins, no error.
- CLEAR (1 cycle):
  - command_out = 0, command_we0 = 1; the core's INS becomes 0 and all units enter reset.
  - -> SETTLE.
- SETTLE:
  - Hold for SETTLE cycles, with command_we0 = 0 and done ignored.
  - Then -> FETCH if the FIFO is non-empty, else -> DONE.
- DONE (1 cycle): seq_done = 1 -> IDLE.

Timing and errors:
- Minimum issue-to-issue spacing is 1 (WAIT) + 1 (CLEAR) + SETTLE + 1 (FETCH) cycles beyond the done cycle.
- Errors are sticky until clear_err=1. If clear_err and a set event occur in the same cycle, set wins.
- All outputs are registered.

Test Plan:
- Push {OP3=0x100, OP2=0, OP1=0, INS=22}. Pulse start. Model done 10 cycles after command_we0. Expect:
  - command_we0 twice: the command, then 35'd0.
  - issued_count=1.
  - seq_done exactly once.
  - busy high from start+1 through the seq_done cycle; ext_grant its inverse.
- Push 16 commands (INS=24) -> cmd_ready=0 after the 16th push. Pulse start, with done 5 cycles after each issue. Expect:
  - 16 issue/NOP pairs in FIFO order.
  - issued_count=16.
  - cmd_ready rises in the FETCH cycle of the first pop.
- Push INS=7, then INS=18, then pulse start. Expect:
  - err_illegal=1.
  - Only INS=18 is issued; issued_count=1.
  - Pulse clear_err -> err_illegal=0.
- TIMEOUT=64, push two INS=19, done never asserted. Expect:
  - err_timeout set at WAIT cycle 64.
  - NOP written, FIFO flushed (second command never issued).
  - seq_done pulses.
- Assert rst_n=0 during WAIT. Expect:
  - Outputs return to reset values asynchronously, before the next clk edge.
  - FIFO empty, cmd_ready=1.
  - After release, a start with an empty FIFO gives only a seq_done pulse.
- Start pulsed during WAIT, and done held high through SETTLE. Expect:
  - The extra start is ignored.
  - No double NOP write.
  - Next issue only after SETTLE completes.
